// File: rtl/write_back_unit.sv
// ---------------------------------------------------------------------------
// write_back_unit
//
// Write-back stage of the pipeline combined with the register file it
// commits into. Selects the write-back word (memory data or ALU result),
// writes it into the register file, forwards it to the decode-stage read
// ports in the same cycle, exposes a registered debug read port and keeps
// a running count of committed register writes.
//
// Parameters
//   NB_ADDR          register-file address width (2**NB_ADDR registers)
//   NB_DATA          data width
//
// Ports
//   i_clock          clock, all state updates on the rising edge
//   i_reset          synchronous, active-low reset
//   i_data_readed    data-memory read word from the memory-access stage
//   i_alu_result     ALU result from the memory-access stage
//   i_rf_wr_enb      register-file write enable
//   i_rf_wr_data_src write-data select: 1 = memory data, 0 = ALU result
//   i_rf_wr_addr     destination register
//   i_rd_addr_a      decode-stage read address A
//   i_rd_addr_b      decode-stage read address B
//   i_dbg_addr       debug read address
//   o_rd_data_a      read data A (combinational, with write bypass)
//   o_rd_data_b      read data B (combinational, with write bypass)
//   o_dbg_data       debug read data, registered, post-write contents
//   o_wb_data        selected write-back data, for forwarding
//   o_wb_wr_enb      effective write strobe (enable and non-zero address)
//   o_wr_count       number of committed register writes (wraps)
// ---------------------------------------------------------------------------
module write_back_unit #(
    parameter int NB_ADDR = 5,
    parameter int NB_DATA = 2**NB_ADDR
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_data_readed,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_rf_wr_enb,
    input  logic               i_rf_wr_data_src,
    input  logic [NB_ADDR-1:0] i_rf_wr_addr,
    input  logic [NB_ADDR-1:0] i_rd_addr_a,
    input  logic [NB_ADDR-1:0] i_rd_addr_b,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic [NB_DATA-1:0] o_rd_data_a,
    output logic [NB_DATA-1:0] o_rd_data_b,
    output logic [NB_DATA-1:0] o_dbg_data,
    output logic [NB_DATA-1:0] o_wb_data,
    output logic               o_wb_wr_enb,
    output logic [NB_DATA-1:0] o_wr_count
);

    localparam int NB_REGS = 2**NB_ADDR;

    logic [NB_DATA-1:0] regs [NB_REGS];
    logic [NB_DATA-1:0] dbg_next;

    // Write-back data select and effective write strobe. A write aimed at
    // register 0 is dropped here, so nothing downstream has to special-case
    // it: the register never changes and the counter never sees it.
    always_comb begin
        o_wb_data   = i_rf_wr_data_src ? i_data_readed : i_alu_result;
        o_wb_wr_enb = i_rf_wr_enb && (i_rf_wr_addr != '0);
    end

    // Read ports are write-first: a read of the register being written this
    // cycle returns the new value. Register 0 is masked explicitly so it reads
    // zero even before the first reset edge has cleared the array. The bypass
    // does not look at i_reset, so forwarding keeps working during reset.
    always_comb begin
        o_rd_data_a = regs[i_rd_addr_a];
        if (i_rd_addr_a == '0) begin
            o_rd_data_a = '0;
        end
        if (o_wb_wr_enb && (i_rd_addr_a == i_rf_wr_addr)) begin
            o_rd_data_a = o_wb_data;
        end

        o_rd_data_b = regs[i_rd_addr_b];
        if (i_rd_addr_b == '0) begin
            o_rd_data_b = '0;
        end
        if (o_wb_wr_enb && (i_rd_addr_b == i_rf_wr_addr)) begin
            o_rd_data_b = o_wb_data;
        end
    end

    // The debug port captures the contents as they will be after this edge's
    // write, so a write and a debug read of the same register in one cycle
    // shows the new value on the following cycle.
    always_comb begin
        dbg_next = regs[i_dbg_addr];
        if (i_dbg_addr == '0) begin
            dbg_next = '0;
        end
        if (o_wb_wr_enb && (i_dbg_addr == i_rf_wr_addr)) begin
            dbg_next = o_wb_data;
        end
    end

    // Register file, debug register and write counter. Reset wins over a
    // write in the same cycle: the write is neither stored nor counted.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            for (int i = 0; i < NB_REGS; i++) begin
                regs[i] <= '0;
            end
            o_dbg_data <= '0;
            o_wr_count <= '0;
        end else begin
            if (o_wb_wr_enb) begin
                regs[i_rf_wr_addr] <= o_wb_data;
                o_wr_count         <= o_wr_count + {{(NB_DATA-1){1'b0}}, 1'b1};
            end
            o_dbg_data <= dbg_next;
        end
    end

endmodule

// File: doc/write_back_unit.md
WRITE_BACK_UNIT -- requirements
Module: write_back_unit

Interface
REQ-001 SHALL have parameter NB_ADDR, default 5: register-file address width.
REQ-002 SHALL have parameter NB_DATA, default 2**NB_ADDR (32): data width.
REQ-003 SHALL have port i_clock  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port i_reset  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port i_data_readed  input  NB_DATA: latched data-memory read word from the memory-access stage.
REQ-006 SHALL have port i_alu_result  input  NB_DATA: latched ALU result from the memory-access stage.
REQ-007 SHALL have port i_rf_wr_enb  input  1: latched register-file write enable.
REQ-008 SHALL have port i_rf_wr_data_src  input  1: write-data select; 1 = memory data, 0 = ALU result.
REQ-009 SHALL have port i_rf_wr_addr  input  NB_ADDR: latched destination register.
REQ-010 SHALL have port i_rd_addr_a  input  NB_ADDR: decode-stage read address A.
REQ-011 SHALL have port i_rd_addr_b  input  NB_ADDR: decode-stage read address B.
REQ-012 SHALL have port i_dbg_addr  input  NB_ADDR: debug read address.
REQ-013 SHALL have port o_rd_data_a  output  NB_DATA: register A read data.
REQ-014 SHALL have port o_rd_data_b  output  NB_DATA: register B read data.
REQ-015 SHALL have port o_dbg_data  output  NB_DATA: debug read data, registered.
REQ-016 SHALL have port o_wb_data  output  NB_DATA: selected write-back data (combinational), for forwarding.
REQ-017 SHALL have port o_wb_wr_enb  output  1: effective write strobe (i_rf_wr_enb and i_rf_wr_addr != 0).
REQ-018 SHALL have port o_wr_count  output  NB_DATA: count of committed register writes.

Function
REQ-019 SHALL compute o_wb_data = i_rf_wr_data_src ? i_data_readed : i_alu_result.
REQ-020 SHALL hold 2**NB_ADDR registers of NB_DATA bits; register 0 SHALL always read 0 and ignore writes.
REQ-021 SHALL write o_wb_data into register i_rf_wr_addr on the rising edge when o_wb_wr_enb = 1 and i_reset = 1.
REQ-022 SHALL provide combinational reads on ports A and B, zero-cycle latency.
REQ-023 SHALL bypass: when o_wb_wr_enb = 1 and a read address equals i_rf_wr_addr, that read port SHALL return o_wb_data in the same cycle (write-first).
REQ-024 SHALL treat A and B independently; both ports may hit the same address or the bypass simultaneously.
REQ-025 SHALL register o_dbg_data one cycle after i_dbg_addr, reading post-write contents (a write in cycle N to address X is visible on o_dbg_data in cycle N+1 when i_dbg_addr = X in cycle N).
REQ-026 SHALL increment o_wr_count by 1 on each rising edge with o_wb_wr_enb = 1; writes to register 0 SHALL NOT count.
REQ-027 SHALL wrap o_wr_count from 2**NB_DATA-1 to 0 without flag.
REQ-028 SHALL ignore i_rf_wr_data_src, i_data_readed and i_alu_result when i_rf_wr_enb = 0 (no state change).

Reset
REQ-029 SHALL, on a rising edge with i_reset = 0, clear all registers to 0, o_wr_count to 0 and o_dbg_data to 0.
REQ-030 SHALL give reset priority over a simultaneous write; the write SHALL be discarded and not counted.
REQ-031 SHALL keep o_wb_data, o_wb_wr_enb, o_rd_data_a/b combinational during reset; o_rd_data_a/b SHALL show register contents (0 after the reset edge), with bypass still active.

Verification
REQ-032 SHALL verify: reset, then wr_enb=1, src=0, addr=5, alu=0xDEADBEEF; next cycle rd_addr_a=5 -> o_rd_data_a=0xDEADBEEF, o_wr_count=1.
REQ-033 SHALL verify: wr_enb=1, src=1, addr=7, data_readed=0x12345678, rd_addr_b=7 same cycle -> o_rd_data_b=0x12345678 (bypass), o_wb_data=0x12345678.
REQ-034 SHALL verify: wr_enb=1, addr=0, alu=0xFFFFFFFF -> o_wb_wr_enb=0, rd_addr_a=0 returns 0, o_wr_count unchanged.
REQ-035 SHALL verify: write r3=0xA5A5A5A5 with i_reset=0 on same edge -> r3 reads 0, o_wr_count=0.
REQ-036 SHALL verify: 32 consecutive writes to r1..r31 then r1, dbg sweep of all addresses -> o_dbg_data matches written values one cycle after each address, o_wr_count=32.
REQ-037 SHALL verify: preload o_wr_count to 0xFFFFFFFF via forced state, one valid write -> o_wr_count=0.
